// File: rtl/sum_seq_n_pkg.sv
// Shared types for the chunked multi-cycle adder/subtractor.
// State encodings are fixed so debug traces stay stable.
package sum_seq_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sum_chunk.sv
// Combinational W-bit adder slice with carry in/out.
// Also exposes the carry into the slice MSB for overflow detection.
module sum_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s     = full[W-1:0];
  assign cout  = full[W];
  // carry into the MSB falls out of the MSB sum bit
  assign c_msb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/sum_seq_n.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per clock, LSB first.
// Carry is registered between chunks; result held until next completion.
module sum_seq_n
  import sum_seq_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   C,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   c_q, c_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] s;
  logic             cout;
  logic             c_msb;

  sum_chunk #(
    .W(CHUNK)
  ) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (s),
    .cout (cout),
    .c_msb(c_msb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B ^ {WIDTH{sub}};
          carry_d = sub;
          sub_d   = sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = (res_q >> CHUNK)
                | (WIDTH'(s) << (WIDTH - CHUNK));
        carry_d = cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = DONE;
          // subtract reports borrow, the inverse of carry
          c_d     = {cout ^ sub_q, res_d};
          ovf_d   = c_msb ^ cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign C    = c_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sum_seq_n.sv
// Directed bench for sum_seq_n: 16/4 main instance, 8/8 single-chunk instance.
module tb_sum_seq_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done, ovf;
  logic [16:0] C;

  logic        start8 = 1'b0;
  logic        sub8 = 1'b0;
  logic [7:0]  A8 = '0;
  logic [7:0]  B8 = '0;
  logic        busy8, done8, ovf8;
  logic [8:0]  C8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sum_seq_n #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .A(A), .B(B), .busy(busy), .done(done), .C(C), .ovf(ovf)
  );

  sum_seq_n #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8),
    .A(A8), .B(B8), .busy(busy8), .done(done8), .C(C8), .ovf(ovf8)
  );

  // issue one op from a negedge; lat = cycles from accept edge to done
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic s, output int lat);
    start = 1'b1; A = a; B = b; sub = s;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, C, ovf} !== 20'd0) begin
      errors++;
      $display("FAIL reset16: busy=%b done=%b C=%h ovf=%b, want all 0",
               busy, done, C, ovf);
    end
    checks++;
    if ({busy8, done8, C8, ovf8} !== 12'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b C=%h ovf=%b, want all 0",
               busy8, done8, C8, ovf8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [15:0] va [3] = '{16'h000A, 16'h0004, 16'h7FFF};
    logic [15:0] vb [3] = '{16'h0002, 16'hFFFF, 16'h0001};
    logic [16:0] ec [3] = '{17'h0000C, 17'h10003, 17'h08000};
    logic        eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL add_lat[%0d]: got %0d want 4", i, lat);
      end
      checks++;
      if (C !== ec[i] || ovf !== eo[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL add[%0d]: C=%h ovf=%b busy=%b want C=%h ovf=%b busy=0",
                 i, C, ovf, busy, ec[i], eo[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || C !== ec[i]) begin
        errors++;
        $display("FAIL add_hold[%0d]: done=%b C=%h want done=0 C=%h",
                 i, done, C, ec[i]);
      end
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(16'h0005, 16'h0005, 1'b1, lat);
    checks++;
    if (lat !== 4 || C !== 17'h00000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_eq: lat=%0d C=%h ovf=%b want 4 00000 0", lat, C, ovf);
    end
    @(negedge clk);
    run_op(16'h0001, 16'h0005, 1'b1, lat);
    checks++;
    if (lat !== 4 || C !== 17'h1FFFC || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: lat=%0d C=%h ovf=%b want 4 1fffc 0", lat, C, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int lat = -1;
    start = 1'b1; A = 16'h1234; B = 16'h1111; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1;
    @(negedge clk);
    start = 1'b0; A = '0; B = '0; sub = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: busy=%b want 1", busy);
    end
    for (int k = 3; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 4 || C !== 17'h02345 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ignore: lat=%0d C=%h ovf=%b want 4 02345 0", lat, C, ovf);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    // entered with done=1 from the previous task
    run_op(16'h8000, 16'h8000, 1'b0, lat);
    checks++;
    if (lat !== 4 || C !== 17'h10000 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d C=%h ovf=%b want 4 10000 1",
               lat, C, ovf);
    end
    start = 1'b1; A = 16'h0003; B = 16'h0007; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || C !== 17'h10000) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b C=%h want 1 0 10000",
               busy, done, C);
    end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 4 || C !== 17'h1FFFC || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d C=%h ovf=%b want 4 1fffc 0",
               lat, C, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    start = 1'b1; A = 16'h0100; B = 16'h0200; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || C !== 17'd0 || ovf !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b C=%h ovf=%b want 0 0 0 0",
               busy, done, C, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0 || C !== 17'd0) begin
      errors++;
      $display("FAIL rst_nodone: active_cycles=%0d C=%h want 0 0", seen, C);
    end
  endtask

  task automatic test_single_chunk();
    int lat = -1;
    start8 = 1'b1; A8 = 8'hFF; B8 = 8'h01; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL n1_busy: busy=%b want 1", busy8);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done8) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 1 || C8 !== 9'h100 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL n1: lat=%0d C=%h ovf=%b want 1 100 0", lat, C8, ovf8);
    end
    start8 = 1'b1; A8 = 8'h7F; B8 = 8'h80; sub8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    checks++;
    if (done8 !== 1'b1 || C8 !== 9'h1FF || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL n1_sub: done=%b C=%h ovf=%b want 1 1ff 1",
               done8, C8, ovf8);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_single_chunk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
